// File: rtl/mul_add_seq.sv
// mul_add_seq: sequential shift-add multiply-accumulate, p = q*b + r (unsigned).
// Latency: start accepted at edge N -> done high in the cycle after edge N+WIDTH+1.
// Backpressure: start is dropped while busy or done; optional r>=b flag via MULADD_RCHECK_EN.
module mul_add_seq #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   r,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
`ifdef MULADD_RCHECK_EN
  ,
  output logic               err
`endif
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  q_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [WIDTH-1:0]  r_reg;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     addend;
  logic [PW-1:0]     sum;
  logic [CW-1:0]     cnt;
  logic              last;

  // One partial product per RUN cycle: b shifted by the current multiplier bit position.
  always_comb begin
    addend = '0;
    if (q_reg[cnt]) addend = {{WIDTH{1'b0}}, b_reg} << cnt;
    sum  = acc + addend;
    last = (cnt == CW'(WIDTH - 1));
  end

  // State register; reset wins over everything, discarding any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        busy      = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, accumulate during RUN, publish the result
  // on the last RUN edge so p is already valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= '0;
      b_reg <= '0;
      r_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            q_reg <= q;
            b_reg <= b;
            r_reg <= r;
            acc   <= {{WIDTH{1'b0}}, r};
            cnt   <= '0;
          end
        end
        RUN: begin
          acc <= sum;
          cnt <= cnt + 1'b1;
          if (last) p <= sum;
        end
        default: ;
      endcase
    end
  end

`ifdef MULADD_RCHECK_EN
  // Remainder sanity flag: a valid division remainder is strictly below the divisor.
  always_ff @(posedge clk) begin
    if (rst)                      err <= 1'b0;
    else if (state == RUN && last) err <= (r_reg >= b_reg);
  end
`endif

endmodule

// File: tb/tb_mul_add_seq.sv
module tb_mul_add_seq;

  localparam int W = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   q = '0;
  logic [W-1:0]   b = '0;
  logic [W-1:0]   r = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;
`ifdef MULADD_RCHECK_EN
  logic           err;
`endif

  mul_add_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .q     (q),
    .b     (b),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .p     (p)
`ifdef MULADD_RCHECK_EN
    ,
    .err   (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   q;
    logic [W-1:0]   b;
    logic [W-1:0]   r;
    logic [2*W-1:0] exp_p;
    logic           exp_err;
  } vec_t;

  typedef struct {
    logic [2*W-1:0] p;
    logic           e;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Wait (bounded) for an idle DUT, present one operation for one cycle, queue its expected result.
  task automatic start_op(input logic [W-1:0] qi, input logic [W-1:0] bi, input logic [W-1:0] ri);
    int   w = 0;
    res_t e;
    while ((busy || done) && w < 40) begin
      @(negedge clk);
      w++;
    end
    q = qi; b = bi; r = ri; start = 1'b1;
    e.p = 12'(int'(qi) * int'(bi) + int'(ri));
    e.e = (ri >= bi);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done, pop the scoreboard and compare; exp_lat < 0 skips the latency check.
  task automatic wait_done(input string name, input int exp_lat);
    int   lat = 0;
    res_t e;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_done: got done expected none queued", name);
    end else begin
      e = exp_q.pop_front();
      check({name, "_p"}, 32'(p), 32'(e.p));
      if (exp_lat >= 0) check({name, "_lat"}, 32'(lat), 32'(exp_lat));
`ifdef MULADD_RCHECK_EN
      check({name, "_err"}, 32'(err), 32'(e.e));
`endif
    end
    @(negedge clk);
  endtask

  vec_t vecs[10];

  initial begin
    int dc;
    vecs[0] = '{q: 6'd5,  b: 6'd6,  r: 6'd3,  exp_p: 12'd33,   exp_err: 1'b0};
    vecs[1] = '{q: 6'd63, b: 6'd63, r: 6'd62, exp_p: 12'd4031, exp_err: 1'b0};
    vecs[2] = '{q: 6'd0,  b: 6'd17, r: 6'd9,  exp_p: 12'd9,    exp_err: 1'b0};
    vecs[3] = '{q: 6'd63, b: 6'd63, r: 6'd63, exp_p: 12'd4032, exp_err: 1'b1};
    vecs[4] = '{q: 6'd0,  b: 6'd0,  r: 6'd0,  exp_p: 12'd0,    exp_err: 1'b1};
    vecs[5] = '{q: 6'd63, b: 6'd0,  r: 6'd5,  exp_p: 12'd5,    exp_err: 1'b1};
    vecs[6] = '{q: 6'd32, b: 6'd1,  r: 6'd1,  exp_p: 12'd33,   exp_err: 1'b1};
    vecs[7] = '{q: 6'd1,  b: 6'd63, r: 6'd0,  exp_p: 12'd63,   exp_err: 1'b0};
    vecs[8] = '{q: 6'd1,  b: 6'd5,  r: 6'd7,  exp_p: 12'd12,   exp_err: 1'b1};
    vecs[9] = '{q: 6'd6,  b: 6'd5,  r: 6'd4,  exp_p: 12'd34,   exp_err: 1'b0};

    // Reset held two cycles with start asserted: nothing may start.
    rst = 1'b1; start = 1'b1; q = 6'd5; b = 6'd6; r = 6'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_p",    32'(p),    32'd0);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Table-driven operations with exact latency.
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].q, vecs[i].b, vecs[i].r);
      if (i == 0) check("load_busy", 32'(busy), 32'd1);
      wait_done($sformatf("vec%0d", i), W + 1);
      check($sformatf("vec%0d_p_tbl", i), 32'(p), 32'(vecs[i].exp_p));
`ifdef MULADD_RCHECK_EN
      check($sformatf("vec%0d_err_tbl", i), 32'(err), 32'(vecs[i].exp_err));
`endif
      check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
      check($sformatf("vec%0d_busy_after", i), 32'(busy), 32'd0);
    end

    // Start pulsed during RUN is dropped: one done, first result only.
    dc = done_cnt;
    start_op(6'd3, 6'd4, 6'd1);
    @(negedge clk); @(negedge clk);
    q = 6'd7; b = 6'd7; r = 6'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("drop", -1);
    check("drop_p_val", 32'(p), 32'd13);
    repeat (12) @(negedge clk);
    check("drop_done_count", 32'(done_cnt - dc), 32'd1);
    check("drop_p_hold", 32'(p), 32'd13);
    check("drop_busy", 32'(busy), 32'd0);

    // Reset in the third RUN cycle discards the operation.
    dc = done_cnt;
    start_op(6'd10, 6'd10, 6'd0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_p",    32'(p),    32'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    repeat (12) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - dc), 32'd0);
    start_op(6'd2, 6'd2, 6'd1);
    wait_done("after_rst", W + 1);

    // Sweep q,b in 0..31 with r=b-1.
    for (int qq = 0; qq < 32; qq++) begin
      for (int bb = 1; bb < 32; bb++) begin
        start_op(6'(qq), 6'(bb), 6'(bb - 1));
        wait_done($sformatf("sweep_q%0d_b%0d", qq, bb), -1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
